// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding and UART register map for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    CFG_BAUD,
    CFG_EN,
    ARB,
    POLL,
    WRITE,
    SETTLE
  } state_t;

  localparam logic [31:0] UART_DATA    = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS  = 32'h0000_0004;
  localparam logic [31:0] UART_CONTROL = 32'h0000_0008;
  localparam logic [31:0] UART_BAUD    = 32'h0000_000C;

  localparam int STATUS_TX_BUSY_BIT = 2;
  localparam int ENTRY_W            = 9;  // {last, data}

endpackage

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// Per-requester queue. The head entry is a registered read of the RAM, so it is
// valid one cycle after the read pointer settles on a stored entry.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset so it maps onto RAM; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
    dout_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds whole byte messages from several requesters into
// a register-mapped UART, configuring the baud divisor and enable after reset.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_DIV   = 16'd434
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                uart_addr,
  output logic [31:0]                uart_wdata,
  output logic                       uart_we,
  output logic                       uart_re,
  input  logic [31:0]                uart_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active
);

  localparam int GW = $clog2(NUM_REQ);

  state_t             state_reg, state_next;
  logic [GW-1:0]      grant_id_reg;
  logic               active_reg;
  logic               last_reg;
  logic [NUM_REQ-1:0] full_vec, empty_vec, pop_vec;
  logic [ENTRY_W-1:0] head [NUM_REQ];
  logic [ENTRY_W-1:0] head_sel;
  logic               pick_valid;
  logic [GW-1:0]      pick_id;
  logic               tx_busy;
  logic               unused_rdata_bits;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
      assign pop_vec[gi]   = (state_reg == WRITE) && (grant_id_reg == GW'(gi));
      assign req_ready[gi] = !full_vec[gi];

      byte_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid[gi]),
        .pop   (pop_vec[gi]),
        .din   ({req_last[gi], req_data[8*gi +: 8]}),
        .dout  (head[gi]),
        .full  (full_vec[gi]),
        .empty (empty_vec[gi])
      );
    end
  endgenerate

  assign head_sel          = head[grant_id_reg];
  assign tx_busy           = uart_rdata[STATUS_TX_BUSY_BIT];
  assign unused_rdata_bits = ^{uart_rdata[31:STATUS_TX_BUSY_BIT+1], uart_rdata[STATUS_TX_BUSY_BIT-1:0]};
  assign grant_id          = grant_id_reg;
  assign active            = active_reg;

  // Walk downward so the nearest non-empty requester after the last owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(grant_id_reg) + k) % NUM_REQ;
      if (!empty_vec[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CFG_BAUD;
      grant_id_reg <= GW'(NUM_REQ - 1);
      active_reg   <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARB && pick_valid) begin
        grant_id_reg <= pick_id;
        active_reg   <= 1'b1;
      end
      if (state_reg == WRITE) last_reg <= head_sel[ENTRY_W-1];
      if (state_reg == SETTLE && last_reg) active_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG_BAUD: state_next = CFG_EN;
      CFG_EN:   state_next = ARB;
      ARB:      state_next = pick_valid ? POLL : ARB;
      POLL:     state_next = tx_busy ? POLL : WRITE;
      WRITE:    state_next = SETTLE;
      SETTLE: begin
        if (last_reg)                      state_next = ARB;
        else if (!empty_vec[grant_id_reg]) state_next = POLL;
        else                               state_next = SETTLE;
      end
      default:  state_next = CFG_BAUD;
    endcase
  end

  // Strobes are held off while reset is asserted even though the state sits in CFG_BAUD.
  always_comb begin
    uart_we    = 1'b0;
    uart_re    = 1'b0;
    uart_addr  = '0;
    uart_wdata = '0;
    if (!rst) begin
      case (state_reg)
        CFG_BAUD: begin
          uart_we    = 1'b1;
          uart_addr  = UART_BAUD;
          uart_wdata = {16'b0, BAUD_DIV};
        end
        CFG_EN: begin
          uart_we    = 1'b1;
          uart_addr  = UART_CONTROL;
          uart_wdata = 32'd1;
        end
        POLL: begin
          uart_re   = 1'b1;
          uart_addr = UART_STATUS;
        end
        WRITE: begin
          uart_we    = 1'b1;
          uart_addr  = UART_DATA;
          uart_wdata = {24'b0, head_sel[7:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-for-N-cycles UART model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NUM_REQ  = 2;
  localparam int BUSY_CYC = 20;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [31:0]          uart_addr;
  logic [31:0]          uart_wdata;
  logic                 uart_we;
  logic                 uart_re;
  logic [31:0]          uart_rdata;
  logic [0:0]           grant_id;
  logic                 active;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  logic [7:0] wr_q [$];
  logic [0:0] gid_q [$];

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (4),
    .BAUD_DIV   (16'd434)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_we    (uart_we),
    .uart_re    (uart_re),
    .uart_rdata (uart_rdata),
    .grant_id   (grant_id),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign uart_rdata = {29'b0, (busy_cnt != 0) || hold_busy, 2'b00};

  // UART model: sampled mid-cycle, records data writes and flags writes while busy.
  always @(negedge clk) begin
    if (uart_we && uart_re) begin
      checks++;
      errors++;
      $display("FAIL strobe_excl we=%0b re=%0b required not both", uart_we, uart_re);
    end
    if (!rst && uart_we && uart_addr == UART_DATA) begin
      checks++;
      if (busy_cnt != 0 || hold_busy) begin
        errors++;
        $display("FAIL write_while_busy byte=%02h busy_cnt=%0d required 0", uart_wdata[7:0], busy_cnt);
      end
      wr_q.push_back(uart_wdata[7:0]);
      gid_q.push_back(grant_id);
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct {
    int         src;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic [0:0] exp_gid;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [7:0] exp_b, input logic [0:0] exp_g);
    if (wr_q.size() > idx) begin
      chk({name, "_byte"}, {24'b0, wr_q[idx]}, {24'b0, exp_b});
      chk({name, "_gid"}, {31'b0, gid_q[idx]}, {31'b0, exp_g});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s missing write index %0d actual_count=%0d", name, idx, wr_q.size());
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    int n;
    req_valid[r]       = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r]        = l;
    n = 0;
    while (!req_ready[r] && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL push_timeout req=%0d byte=%02h ready=%0b required 1", r, d, req_ready[r]);
    end
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c;
    c = 0;
    while (wr_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("write_count", wr_q.size(), n);
  endtask

  task automatic check_cfg();
    chk("cfg1_we", {31'b0, uart_we}, 32'd1);
    chk("cfg1_addr", uart_addr, UART_BAUD);
    chk("cfg1_wdata", uart_wdata, 32'd434);
    tick();
    chk("cfg2_we", {31'b0, uart_we}, 32'd1);
    chk("cfg2_addr", uart_addr, UART_CONTROL);
    chk("cfg2_wdata", uart_wdata, 32'd1);
    tick();
    chk("arb_strobes", {30'b0, uart_we, uart_re}, 32'd0);
    chk("arb_addr", uart_addr, 32'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_ready", {30'b0, req_ready}, 32'h3);
    chk("rst_strobes", {30'b0, uart_we, uart_re}, 32'd0);
    chk("rst_addr", uart_addr, 32'd0);
    chk("rst_wdata", uart_wdata, 32'd0);
    chk("rst_grant", {31'b0, grant_id}, 32'd1);
    chk("rst_active", {31'b0, active}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    vecs[0] = '{src: 0, b0: 8'h41, b1: 8'h42, exp0: 8'h41, exp1: 8'h42, exp_gid: 1'b0};
    vecs[1] = '{src: 1, b0: 8'h55, b1: 8'hAA, exp0: 8'h55, exp1: 8'hAA, exp_gid: 1'b1};
    vecs[2] = '{src: 0, b0: 8'h00, b1: 8'hFF, exp0: 8'h00, exp1: 8'hFF, exp_gid: 1'b0};
    vecs[3] = '{src: 1, b0: 8'h7E, b1: 8'h81, exp0: 8'h7E, exp1: 8'h81, exp_gid: 1'b1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    #1;
    check_cfg();

    // Single-requester two-byte messages against the 20-cycle busy UART.
    for (int v = 0; v < 4; v++) begin
      base = wr_q.size();
      push_byte(vecs[v].src, vecs[v].b0, 1'b0);
      push_byte(vecs[v].src, vecs[v].b1, 1'b1);
      wait_writes(base + 2, 200);
      chk_wr($sformatf("vec%0d_w0", v), base,     vecs[v].exp0, vecs[v].exp_gid);
      chk_wr($sformatf("vec%0d_w1", v), base + 1, vecs[v].exp1, vecs[v].exp_gid);
      tick(); tick(); tick();
      chk($sformatf("vec%0d_active_clear", v), {31'b0, active}, 32'd0);
    end

    // Two messages offered together: no interleaving, req0 first after req1 owned last.
    base = wr_q.size();
    chk("both_ready", {30'b0, req_ready}, 32'h3);
    req_valid = 2'b11;
    req_data  = {8'h43, 8'h41};
    req_last  = 2'b00;
    tick();
    req_data  = {8'h44, 8'h42};
    req_last  = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_writes(base + 4, 300);
    chk_wr("il_A", base,     8'h41, 1'b0);
    chk_wr("il_B", base + 1, 8'h42, 1'b0);
    chk_wr("il_C", base + 2, 8'h43, 1'b1);
    chk_wr("il_D", base + 3, 8'h44, 1'b1);
    tick(); tick(); tick();

    // Req1 finishes a message, then both pend: round-robin gives req0.
    base = wr_q.size();
    push_byte(1, 8'h58, 1'b1);
    wait_writes(base + 1, 200);
    tick(); tick(); tick();
    req_valid = 2'b11;
    req_data  = {8'h47, 8'h45};
    req_last  = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_writes(base + 3, 300);
    chk_wr("rr_X", base,     8'h58, 1'b1);
    chk_wr("rr_E", base + 1, 8'h45, 1'b0);
    chk_wr("rr_G", base + 2, 8'h47, 1'b1);
    tick(); tick(); tick();

    // Backpressure: UART held busy, FIFO fills after 4 bytes, 5th waits at the source.
    hold_busy = 1'b1;
    base = wr_q.size();
    for (int i = 0; i < 4; i++) push_byte(0, 8'h10 + 8'(i), 1'b0);
    chk("bp_ready_low", {31'b0, req_ready[0]}, 32'd0);
    req_valid[0]    = 1'b1;
    req_data[7:0]   = 8'h14;
    req_last[0]     = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_ready_still_low", {31'b0, req_ready[0]}, 32'd0);
    chk("bp_no_writes", wr_q.size(), base);
    hold_busy = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 300) begin
      tick();
      n++;
    end
    chk("bp_ready_returns", {31'b0, req_ready[0]}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    wait_writes(base + 5, 400);
    for (int i = 0; i < 5; i++)
      chk_wr($sformatf("bp_w%0d", i), base + i, 8'h10 + 8'(i), 1'b0);
    tick(); tick(); tick();

    // Reset mid-message discards the rest and reruns configuration.
    base = wr_q.size();
    for (int i = 0; i < 4; i++) push_byte(0, 8'h21 + 8'(i), (i == 3));
    wait_writes(base + 2, 300);
    rst = 1'b1;
    #1;
    check_reset_state();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_cfg();
    for (int i = 0; i < 80; i++) tick();
    chk("rst_discard_count", wr_q.size(), base + 2);
    chk("rst_idle_active", {31'b0, active}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, sets the number of byte-stream requesters (2..4).
REQ-002 Parameter FIFO_DEPTH, default 4, sets entries per requester FIFO (power of 2).
REQ-003 Parameter BAUD_DIV, default 16'd434, is the divisor written to the UART baud register after reset.
REQ-004 Port clk, input, 1, is the clock; all state is updated on the rising edge.
REQ-005 Port rst, input, 1, is the reset: asynchronous, active-high.
REQ-006 Port req_valid, input, NUM_REQ, marks a byte offered by each requester.
REQ-007 Port req_data, input, 8*NUM_REQ, carries the byte; requester i uses bits [8i+7:8i].
REQ-008 Port req_last, input, NUM_REQ, marks the final byte of a message.
REQ-009 Port req_ready, output, NUM_REQ, is high when requester i's FIFO is not full.
REQ-010 Port uart_addr, output, 32, is the UART register address.
REQ-011 Port uart_wdata, output, 32, is the UART write data.
REQ-012 Port uart_we, output, 1, is the UART write strobe.
REQ-013 Port uart_re, output, 1, is the UART read strobe.
REQ-014 Port uart_rdata, input, 32, is the UART combinational read data.
REQ-015 Port grant_id, output, clog2(NUM_REQ), identifies the current owner.
REQ-016 Port active, output, 1, is high while a message is locked to an owner.

Function
REQ-017 A byte SHALL enter FIFO i on any edge where req_valid[i] and req_ready[i] are both high; each entry stores {last, data}.
REQ-018 req_ready[i] SHALL depend only on FIFO i being full, so a push into a full FIFO is never accepted, including when a pop occurs on the same edge.
REQ-019 FSM states: CFG_BAUD, CFG_EN, ARB, POLL, WRITE, SETTLE.
REQ-020 CFG_BAUD SHALL drive uart_we=1, uart_addr=`UART_BAUD and uart_wdata=BAUD_DIV for one cycle, then go to CFG_EN.
REQ-021 CFG_EN SHALL drive uart_we=1, uart_addr=`UART_CONTROL and uart_wdata=1 for one cycle, then go to ARB.
REQ-022 ARB SHALL select the first non-empty FIFO searching round-robin from (last owner+1) mod NUM_REQ, load grant_id, set active and go to POLL.
REQ-023 ARB SHALL remain in ARB while all FIFOs are empty.
REQ-024 POLL SHALL drive uart_re=1 and uart_addr=`UART_STATUS; it SHALL go to WRITE when uart_rdata[2]==0 (tx_busy clear) and otherwise remain in POLL.
REQ-025 WRITE SHALL drive uart_we=1, uart_addr=`UART_DATA and uart_wdata={24'b0, head byte of FIFO[grant_id]}, and SHALL pop that FIFO on the same edge.
REQ-026 WRITE SHALL always be followed by exactly one SETTLE cycle, with both strobes low, so that the UART busy flag is registered before the next poll.
REQ-027 On leaving SETTLE: if the popped entry had last=1, the block SHALL clear active and go to ARB.
REQ-028 On leaving SETTLE with last=0: if the owner's FIFO is non-empty the block SHALL go to POLL; if it is empty it SHALL wait in SETTLE with grant held, so messages are never interleaved.
REQ-029 Only one of uart_we and uart_re SHALL be high in any cycle; in ARB and SETTLE, uart_addr and uart_wdata SHALL be 0.
REQ-030 The minimum byte period SHALL be 3 cycles (POLL, WRITE, SETTLE); the UART baud period dominates in practice.

Reset
REQ-031 On rst: FIFOs empty, req_ready all 1, uart_we=uart_re=0, uart_addr=uart_wdata=0, grant_id=NUM_REQ-1, active=0, state=CFG_BAUD.
REQ-032 Reset asserted mid-message SHALL discard all queued bytes; the byte already in the UART is not tracked.

Structure
REQ-033 The state encoding and the register-address constants SHALL come from memory_map.vh or a shared header; no addresses SHALL be hard-coded.
REQ-034 The per-requester queue SHALL be a sub-module byte_fifo (width 9, depth FIFO_DEPTH, push/pop/full/empty), instantiated NUM_REQ times.

Verification
REQ-035 Reset release -> cycle 1: uart_we with `UART_BAUD and wdata 434; cycle 2: uart_we with `UART_CONTROL and wdata 1; then ARB.
REQ-036 Req0 sends 0x41 and 0x42 (last=1) against a UART model busy 20 cycles per byte -> UART receives writes 0x41 then 0x42, and no write occurs while status bit2=1.
REQ-037 Req0 sends "AB" (last on B) and req1 sends "CD" simultaneously -> UART order is A, B, C, D; grant_id goes 0 then 1.
REQ-038 Req1 finishes a message, then both requesters are pending -> req0 is granted next (round-robin).
REQ-039 Push 5 bytes into req0 while the UART is held busy -> req_ready[0] falls after 4 bytes and the 5th byte is held by the source, not lost.
REQ-040 Assert rst after 2 of 4 queued bytes -> FIFOs empty, both strobes 0, and the CFG sequence repeats.
